// File: rtl/elevator_control.sv
// Four-floor single-car elevator controller that serves latched calls in sweep (SCAN) order.
// Latency: Moore outputs are registered. A call is acted on at the clock edge that first samples it.
// Backpressure: none. Calls are always accepted and held in pending until served.
// Optional build macro IDLE_HOME_EN: an idle car away from floor 0 returns there after IDLE_HOME_CYCLES.
module elevator_control #(
   parameter int FLOOR_TRAVEL_CYCLES = 2,
   parameter int DOOR_OPEN_CYCLES    = 3,
   parameter int IDLE_HOME_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] floor_req,
   input  logic       emergency_stop,
   output logic       move_up,
   output logic       move_down,
   output logic       motor_stop,
   output logic [1:0] current_floor
);

   typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_DOOR, S_EMERG} state_t;

   localparam int TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_OPEN_CYCLES + 1);

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_floor, w_floor_nxt, w_arr_floor;
   logic [3:0]      r_pending, w_eff, w_clr;
   logic [TW-1:0]   r_travel, w_travel_nxt;
   logic [DW-1:0]   r_door, w_door_nxt;
   logic            r_last_up, w_last_up_nxt;
   logic            r_up, r_dn, r_stop;
   logic            w_up_nxt, w_dn_nxt, w_stop_nxt;
   logic            w_above, w_below, w_beyond, w_at_limit;
   logic            w_travel_done, w_door_done;
   logic            w_homing, w_home_go;

   // Any call strictly above floor f.
   function automatic logic any_above(input logic [3:0] m, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++)
         if (i > int'(f)) r = r | m[i];
      return r;
   endfunction

   // Any call strictly below floor f.
   function automatic logic any_below(input logic [3:0] m, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++)
         if (i < int'(f)) r = r | m[i];
      return r;
   endfunction

   // A call is acted on in the same cycle it is sampled.
   assign w_eff         = r_pending | floor_req;
   assign w_above       = any_above(w_eff, r_floor);
   assign w_below       = any_below(w_eff, r_floor);
   assign w_travel_done = (r_travel == TW'(FLOOR_TRAVEL_CYCLES - 1));
   assign w_door_done   = (r_door == DW'(DOOR_OPEN_CYCLES - 1));
   assign w_arr_floor   = (r_state == S_UP) ? r_floor + 2'd1 : r_floor - 2'd1;
   assign w_at_limit    = ((r_state == S_UP) && (r_floor == 2'd3)) ||
                          ((r_state == S_DOWN) && (r_floor == 2'd0));
   // A homing sweep keeps going down even though no call lies below it.
   assign w_beyond      = (r_state == S_UP) ? any_above(w_eff, w_arr_floor)
                        : (any_below(w_eff, w_arr_floor) || (w_homing && (w_arr_floor != 2'd0)));

`ifdef IDLE_HOME_EN
   localparam int HW = $clog2(IDLE_HOME_CYCLES + 1);
   logic [HW-1:0] r_idle_cnt;
   logic          r_homing;
   logic          w_idle_empty;

   assign w_idle_empty = (r_state == S_IDLE) && (w_eff == 4'd0) && (r_floor != 2'd0);
   assign w_home_go    = w_idle_empty && (r_idle_cnt == HW'(IDLE_HOME_CYCLES - 1));
   assign w_homing     = r_homing;

   // Count consecutive empty idle cycles; flag the sweep that homing starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idle_cnt <= '0;
         r_homing   <= 1'b0;
      end else begin
         r_idle_cnt <= (w_idle_empty && !emergency_stop && !w_home_go) ? r_idle_cnt + HW'(1) : '0;
         if (!emergency_stop && w_home_go) r_homing <= 1'b1;
         else if (w_state_nxt != S_DOWN)   r_homing <= 1'b0;
      end
   end
`else
   // Homing is not built in. The parameter only matters when the feature is present.
   assign w_home_go = (IDLE_HOME_CYCLES < 0);
   assign w_homing  = 1'b0;
`endif

   // State, position, call and timer registers, plus registered motor outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_floor   <= 2'd0;
         r_pending <= 4'd0;
         r_travel  <= '0;
         r_door    <= '0;
         r_last_up <= 1'b1;
         r_up      <= 1'b0;
         r_dn      <= 1'b0;
         r_stop    <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_floor   <= w_floor_nxt;
         r_pending <= w_eff & ~w_clr;
         r_travel  <= w_travel_nxt;
         r_door    <= w_door_nxt;
         r_last_up <= w_last_up_nxt;
         r_up      <= w_up_nxt;
         r_dn      <= w_dn_nxt;
         r_stop    <= w_stop_nxt;
      end
   end

   // Dispatch, travel, dwell and emergency decisions.
   always_comb begin
      w_state_nxt   = r_state;
      w_floor_nxt   = r_floor;
      w_clr         = 4'd0;
      w_travel_nxt  = r_travel;
      w_door_nxt    = r_door;
      w_last_up_nxt = r_last_up;
      if (emergency_stop) begin
         w_state_nxt  = S_EMERG;
         w_travel_nxt = '0;
         w_door_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_travel_nxt = '0;
               w_door_nxt   = '0;
               if (w_eff[r_floor]) begin
                  w_state_nxt     = S_DOOR;
                  w_clr[r_floor]  = 1'b1;
               end else if (w_above && w_below) begin
                  w_state_nxt = r_last_up ? S_UP : S_DOWN;
               end else if (w_above) begin
                  w_state_nxt   = S_UP;
                  w_last_up_nxt = 1'b1;
               end else if (w_below || w_home_go) begin
                  w_state_nxt   = S_DOWN;
                  w_last_up_nxt = 1'b0;
               end
            end
            S_UP, S_DOWN: begin
               if (w_at_limit) begin
                  w_state_nxt  = S_IDLE;
                  w_travel_nxt = '0;
               end else if (!w_travel_done) begin
                  w_travel_nxt = r_travel + TW'(1);
               end else begin
                  // One floor covered: stop if called here, else keep sweeping.
                  w_travel_nxt  = '0;
                  w_floor_nxt   = w_arr_floor;
                  w_last_up_nxt = (r_state == S_UP);
                  if (w_eff[w_arr_floor]) begin
                     w_state_nxt        = S_DOOR;
                     w_door_nxt         = '0;
                     w_clr[w_arr_floor] = 1'b1;
                  end else if (!w_beyond) begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            S_DOOR: begin
               // Calls for the floor we are standing at are absorbed by the open door.
               w_clr[r_floor] = 1'b1;
               if (floor_req[r_floor]) begin
                  w_door_nxt = '0;
               end else if (!w_door_done) begin
                  w_door_nxt = r_door + DW'(1);
               end else begin
                  w_door_nxt   = '0;
                  w_travel_nxt = '0;
                  if (r_last_up ? w_above : w_below) begin
                     w_state_nxt = r_last_up ? S_UP : S_DOWN;
                  end else if (r_last_up ? w_below : w_above) begin
                     w_state_nxt   = r_last_up ? S_DOWN : S_UP;
                     w_last_up_nxt = !r_last_up;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt  = S_IDLE;
               w_travel_nxt = '0;
               w_door_nxt   = '0;
            end
         endcase
      end
   end

   // Motor commands decoded from the next state so that the outputs come straight from registers.
   always_comb begin
      w_up_nxt   = (w_state_nxt == S_UP);
      w_dn_nxt   = (w_state_nxt == S_DOWN);
      w_stop_nxt = !((w_state_nxt == S_UP) || (w_state_nxt == S_DOWN));
   end

   assign move_up       = r_up;
   assign move_down     = r_dn;
   assign motor_stop    = r_stop;
   assign current_floor = r_floor;

endmodule

// File: tb/tb_elevator_control.sv
// Directed bench for elevator_control. Each step has a hand-computed expected output set.
module tb_elevator_control;

   logic       clk;
   logic       reset;
   logic [3:0] floor_req;
   logic       emergency_stop;
   logic       move_up, move_down, motor_stop;
   logic [1:0] current_floor;

   int n_checks = 0;
   int n_errors = 0;

   elevator_control #(
      .FLOOR_TRAVEL_CYCLES(2),
      .DOOR_OPEN_CYCLES(3),
      .IDLE_HOME_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .floor_req(floor_req),
      .emergency_stop(emergency_stop),
      .move_up(move_up),
      .move_down(move_down),
      .motor_stop(motor_stop),
      .current_floor(current_floor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic e_up, input logic e_dn,
                      input logic e_st, input logic [1:0] e_fl);
      logic [4:0] obs;
      logic [4:0] exp_v;
      obs   = {move_up, move_down, motor_stop, current_floor};
      exp_v = {e_up, e_dn, e_st, e_fl};
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed up/dn/stop/floor=%b required %b", tag, obs, exp_v);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      floor_req      = 4'd0;
      emergency_stop = 1'b0;
      ticks(3);
      chk("rst_hold", 0, 0, 1, 2'd0);
      reset = 1'b1;
      tick();
      chk("rst_idle", 0, 0, 1, 2'd0);

      // Call floor 3 from floor 0
      floor_req = 4'b1000; tick(); floor_req = 4'd0;
      chk("up_start", 1, 0, 0, 2'd0);
      tick();     chk("up_e1", 1, 0, 0, 2'd0);
      tick();     chk("up_f1", 1, 0, 0, 2'd1);
      ticks(2);   chk("up_f2", 1, 0, 0, 2'd2);
      ticks(2);   chk("up_f3_stop", 0, 0, 1, 2'd3);
      ticks(2);   chk("dwell_f3", 0, 0, 1, 2'd3);
      tick();

      // Call floor 1 from floor 3
      floor_req = 4'b0010; tick(); floor_req = 4'd0;
      chk("dn_start", 0, 1, 0, 2'd3);
      ticks(2);   chk("dn_f2", 0, 1, 0, 2'd2);
      ticks(2);   chk("dn_f1_stop", 0, 0, 1, 2'd1);
      ticks(3);
      ticks(4);   chk("f1_idle", 0, 0, 1, 2'd1);

      // Back to floor 0
      floor_req = 4'b0001; tick(); floor_req = 4'd0;
      chk("dn_to_0", 0, 1, 0, 2'd1);
      ticks(2);   chk("f0_stop", 0, 0, 1, 2'd0);
      ticks(3);

      // Emergency stop mid-travel
      floor_req = 4'b1000; tick(); floor_req = 4'd0;
      chk("em_up", 1, 0, 0, 2'd0);
      ticks(2);   chk("em_f1", 1, 0, 0, 2'd1);
      emergency_stop = 1'b1;
      tick();     chk("em_stop", 0, 0, 1, 2'd1);
      ticks(2);   chk("em_frozen", 0, 0, 1, 2'd1);
      emergency_stop = 1'b0;
      tick();     chk("em_idle", 0, 0, 1, 2'd1);
      tick();     chk("em_resume", 1, 0, 0, 2'd1);
      tick();     chk("em_resume_e1", 1, 0, 0, 2'd1);
      tick();     chk("em_resume_f2", 1, 0, 0, 2'd2);
      ticks(2);   chk("em_f3_stop", 0, 0, 1, 2'd3);
      ticks(3);

      // Return to floor 0 for the sweep test
      floor_req = 4'b0001; tick(); floor_req = 4'd0;
      chk("ret_dn", 0, 1, 0, 2'd3);
      ticks(6);   chk("ret_f0", 0, 0, 1, 2'd0);
      ticks(3);

      // Multi-request sweep with an opposite call during the up sweep
      floor_req = 4'b1010; tick(); floor_req = 4'd0;
      chk("sw_up", 1, 0, 0, 2'd0);
      ticks(2);   chk("sw_stop_f1", 0, 0, 1, 2'd1);
      tick();
      floor_req = 4'b0001; tick(); floor_req = 4'd0;
      chk("sw_dwell_f1", 0, 0, 1, 2'd1);
      tick();     chk("sw_continue_up", 1, 0, 0, 2'd1);
      ticks(4);   chk("sw_stop_f3", 0, 0, 1, 2'd3);
      ticks(3);   chk("sw_reverse_dn", 0, 1, 0, 2'd3);
      ticks(4);   chk("sw_pass_f1", 0, 1, 0, 2'd1);
      ticks(2);   chk("sw_stop_f0", 0, 0, 1, 2'd0);
      ticks(3);

      // Go to floor 2
      floor_req = 4'b0100; tick(); floor_req = 4'd0;
      ticks(4);   chk("to_f2", 0, 0, 1, 2'd2);
      ticks(3);

      // Call at the current floor; a repeat during the dwell restarts it
      floor_req = 4'b0100; tick(); floor_req = 4'd0;
      chk("door_here", 0, 0, 1, 2'd2);
      tick();
      floor_req = 4'b0100; tick();
      floor_req = 4'b1000; tick(); floor_req = 4'd0;
      chk("dwell_restart", 0, 0, 1, 2'd2);
      tick();     chk("dwell_restart_e4", 0, 0, 1, 2'd2);
      tick();     chk("leave_after_dwell", 1, 0, 0, 2'd2);
      ticks(2);   chk("here_f3_stop", 0, 0, 1, 2'd3);
      ticks(3);
      ticks(20);  chk("absorbed_no_home", 0, 0, 1, 2'd3);

      // Calls are latched while the emergency stop is held
      emergency_stop = 1'b1; floor_req = 4'b0001; tick(); floor_req = 4'd0;
      chk("em2_stop", 0, 0, 1, 2'd3);
      tick();     chk("em2_hold", 0, 0, 1, 2'd3);
      emergency_stop = 1'b0;
      tick();     chk("em2_idle", 0, 0, 1, 2'd3);
      tick();     chk("em2_latched_dn", 0, 1, 0, 2'd3);
      ticks(2);   chk("em2_f2", 0, 1, 0, 2'd2);

      // Asynchronous reset mid-travel
      reset = 1'b0;
      #1;         chk("rst_async", 0, 0, 1, 2'd0);
      ticks(2);
      reset = 1'b1;
      tick();     chk("rst_after", 0, 0, 1, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
